dcache_dm: RTL and testbench



---
 rtl/dcache_dm.sv | 154 +++++++++++++++
 tb/tb_dcache_dm.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/dcache_dm.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_dm #(
    parameter int SETS          = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    output logic [DATA_WIDTH-1:0]    rdata_o,
    output logic                     stall_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
    input  logic                     mem_ack_i,
    output logic [31:0]              hit_count_o,
    output logic [31:0]              miss_count_o
);
    localparam int IDX   = $clog2(SETS);
    localparam int TAG_W = ADDRESS_WIDTH - IDX - 2;

    typedef enum logic [1:0] {IDLE, RMISS, WRITE, WDONE} state_t;
    state_t stateReg, stateNext;

    logic [SETS-1:0]            validReg;
    logic [TAG_W-1:0]           tagMem  [SETS];
    logic [DATA_WIDTH-1:0]      dataMem [SETS];
    logic [ADDRESS_WIDTH-3:0]   addrReg;
    logic [DATA_WIDTH-1:0]      wdataReg;

    logic [IDX-1:0]   reqIdx, fillIdx;
    logic [TAG_W-1:0] reqTag, fillTag;
    logic             hit, idleLoadHit, fillEn, storeHitEn;
    logic             stallComb, memReqComb, memWeComb, capture;
    logic             unusedAddrBits;

    assign reqIdx  = addr_i[IDX+1:2];
    assign reqTag  = addr_i[ADDRESS_WIDTH-1:IDX+2];
    assign fillIdx = addrReg[IDX-1:0];
    assign fillTag = addrReg[ADDRESS_WIDTH-3:IDX];
    assign unusedAddrBits = ^addr_i[1:0];

    assign hit         = req_i & validReg[reqIdx] & (tagMem[reqIdx] == reqTag);
    assign idleLoadHit = (stateReg == IDLE) & hit & ~we_i;
    assign fillEn      = (stateReg == RMISS) & mem_ack_i;
    assign storeHitEn  = (stateReg == IDLE) & req_i & we_i & hit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stateReg <= IDLE;
            addrReg  <= '0;
            wdataReg <= '0;
        end else begin
            stateReg <= stateNext;
            if (capture) begin
                addrReg  <= addr_i[ADDRESS_WIDTH-1:2];
                wdataReg <= wdata_i;
            end
        end
    end

    always_comb begin
        stateNext  = stateReg;
        stallComb  = 1'b0;
        memReqComb = 1'b0;
        memWeComb  = 1'b0;
        capture    = 1'b0;
        case (stateReg)
            IDLE: begin
                if (req_i && (we_i || !hit)) begin
                    stallComb = 1'b1;
                    capture   = 1'b1;
                    stateNext = we_i ? WRITE : RMISS;
                end
            end
            RMISS: begin
                memReqComb = 1'b1;
                stallComb  = 1'b1;
                if (mem_ack_i) stateNext = IDLE;
            end
            WRITE: begin
                memReqComb = 1'b1;
                memWeComb  = 1'b1;
                stallComb  = 1'b1;
                if (mem_ack_i) stateNext = WDONE;
            end
            WDONE:   stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Stall is combinational from req_i in IDLE, so it is masked while reset is held.
    assign stall_o     = stallComb & ~rst_i;
    assign mem_req_o   = memReqComb;
    assign mem_we_o    = memWeComb;
    assign mem_addr_o  = {addrReg, 2'b00};
    assign mem_wdata_o = wdataReg;
    assign rdata_o     = idleLoadHit ? dataMem[reqIdx] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < SETS; gi++) begin : g_valid
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i)
                    validReg[gi] <= 1'b0;
                else if (fillEn && (fillIdx == IDX'(gi)))
                    validReg[gi] <= 1'b1;
            end
        end
    endgenerate

    // Line contents are don't-care until the valid bit is set, so no reset here.
    always_ff @(posedge clk_i) begin
        if (fillEn) begin
            dataMem[fillIdx] <= mem_rdata_i;
            tagMem[fillIdx]  <= fillTag;
        end else if (storeHitEn) begin
            dataMem[reqIdx] <= wdata_i;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hitCountReg, missCountReg;
    logic        retryReg;

    // The held load re-presented right after a fill is part of the miss, not a new hit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hitCountReg  <= '0;
            missCountReg <= '0;
            retryReg     <= 1'b0;
        end else begin
            retryReg <= fillEn;
            if (idleLoadHit && !retryReg && (hitCountReg != '1))
                hitCountReg <= hitCountReg + 32'd1;
            if ((stateReg == IDLE) && (stateNext == RMISS) && (missCountReg != '1))
                missCountReg <= missCountReg + 32'd1;
        end
    end

    assign hit_count_o  = hitCountReg;
    assign miss_count_o = missCountReg;
`else
    assign hit_count_o  = '0;
    assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm: reference cache model, backing-memory responder and
// a queue of expected load data compared when the DUT releases the stall.
module tb_dcache_dm;
    localparam int SETS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdataO;
    logic        stall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [31:0] memRdata = '0;
    logic        memAck = 1'b0;
    logic [31:0] hitCnt;
    logic [31:0] missCnt;

    always #5 clk = ~clk;

    dcache_dm #(.SETS(SETS), .DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdataO), .stall_o(stall), .mem_req_o(memReq),
        .mem_we_o(memWe), .mem_addr_o(memAddr), .mem_wdata_o(memWdata),
        .mem_rdata_i(memRdata), .mem_ack_i(memAck), .hit_count_o(hitCnt),
        .miss_count_o(missCnt)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] expQ[$];

    bit          mValid [SETS];
    logic [25:0] mTag   [SETS];
    logic [31:0] mData  [SETS];
    logic [31:0] backMem [logic [31:0]];
    int          mHits = 0;
    int          mMisses = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] backRead(input logic [31:0] a);
        return backMem.exists(a) ? backMem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic checkCounters(input string tag);
`ifdef DCACHE_STATS_EN
        check({tag, "_hits"}, hitCnt, 32'(mHits));
        check({tag, "_misses"}, missCnt, 32'(mMisses));
`else
        check({tag, "_hits"}, hitCnt, 32'd0);
        check({tag, "_misses"}, missCnt, 32'd0);
`endif
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int ackDelay);
        int          idx;
        logic [25:0] t;
        logic [31:0] wa;
        logic [31:0] expData;
        bit          isHit;
        bit          done;
        int          stallCycles;
        int          reqCycles;
        wa    = {a[31:2], 2'b00};
        idx   = int'(a[5:2]);
        t     = a[31:6];
        isHit = mValid[idx] && (mTag[idx] == t);
        if (!w) expQ.push_back(isHit ? mData[idx] : backRead(wa));
        @(posedge clk); #1;
        req = 1'b1; we = w; addr = a; wdata = d;
        stallCycles = 0;
        reqCycles = 0;
        done = 0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            @(negedge clk);
            memAck = 1'b0;
            if (memReq) begin
                reqCycles++;
                if (reqCycles == 1) begin
                    check("mem_addr", memAddr, wa);
                    check("mem_we", 32'(memWe), 32'(w));
                    if (w) check("mem_wdata", memWdata, d);
                end
                if (reqCycles == ackDelay) begin
                    memAck = 1'b1;
                    memRdata = backRead(wa);
                end
            end
            if (!stall) done = 1;
            else stallCycles++;
        end
        check("stall_released", 32'(done), 32'd1);
        check("stall_cycles", 32'(stallCycles), (!w && isHit) ? 32'd0 : 32'(ackDelay + 1));
        check("req_cycles", 32'(reqCycles), (!w && isHit) ? 32'd0 : 32'(ackDelay));
        if (!w) begin
            expData = expQ.pop_front();
            check("rdata", rdataO, expData);
        end
        if (w) begin
            backMem[wa] = d;
            if (isHit) mData[idx] = d;
        end else if (isHit) begin
            mHits++;
        end else begin
            mValid[idx] = 1'b1;
            mTag[idx] = t;
            mData[idx] = backRead(wa);
            mMisses++;
        end
        $display("txn %s addr=%h wdata=%h hit=%0d stall_cycles=%0d req_cycles=%0d rdata=%h",
                 w ? "ST" : "LD", a, d, isHit, stallCycles, reqCycles, rdataO);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        checkCounters("counters");
    endtask

    initial begin
        backMem[32'h40] = 32'hDEAD_BEEF;
        backMem[32'h80] = 32'h0BAD_F00D;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_req", 32'(memReq), 32'd0);
        check("rst_mem_we", 32'(memWe), 32'd0);
        check("rst_mem_addr", memAddr, 32'd0);
        check("rst_mem_wdata", memWdata, 32'd0);
        check("rst_rdata", rdataO, 32'd0);
        checkCounters("rst");

        access(1'b0, 32'h40, 32'h0, 3);            // cold miss, 0xDEADBEEF
        access(1'b0, 32'h40, 32'h0, 1);            // hit
        access(1'b1, 32'h40, 32'h1234_5678, 1);    // store hit
        access(1'b0, 32'h40, 32'h0, 1);            // hit with new data
        access(1'b1, 32'h80, 32'hCAFE_F00D, 2);    // store miss, no allocate
        access(1'b0, 32'h80, 32'h0, 2);            // miss, evicts 0x40
        access(1'b0, 32'h40, 32'h0, 1);            // conflict miss
        access(1'b0, 32'h80, 32'h0, 1);            // conflict miss again
        for (int k = 0; k < 6; k++)
            access(k[0], 32'h1000_0000 + 32'(k * 4), 32'hA000_0000 + 32'(k), 1 + (k % 3));
        for (int k = 0; k < 6; k++)
            access(1'b0, 32'h1000_0000 + 32'(k * 4), 32'h0, 2);

        // Reset in the middle of a read miss; a late ack must be ignored.
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; addr = 32'h40;
        for (int cyc = 0; cyc < 10 && !memReq; cyc++) @(negedge clk);
        check("pre_rst_mem_req", 32'(memReq), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrst_mem_req", 32'(memReq), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        memAck = 1'b1;
        memRdata = 32'hFFFF_0000;
        @(negedge clk);
        memAck = 1'b0;
        check("late_ack_mem_req", 32'(memReq), 32'd0);
        check("late_ack_stall", 32'(stall), 32'd0);
        for (int i = 0; i < SETS; i++) mValid[i] = 1'b0;
        mHits = 0;
        mMisses = 0;
        $display("txn RST mid-RMISS addr=00000040 late_ack ignored");
        checkCounters("post_rst");
        access(1'b0, 32'h40, 32'h0, 2);            // must miss again
        access(1'b0, 32'h40, 32'h0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
